// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - MIPS write-back stage: result select, GPR and HI/LO file, BREAK halt, retire counter
module writeback_regfile (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        RegWriteW,
   input  logic        MemtoRegW,
   input  logic        LinkW,
   input  logic [31:0] ReadDataW,
   input  logic [31:0] ALUOutW,
   input  logic [4:0]  WriteRegW,
   input  logic [31:0] PCPlus8W,
   input  logic        WriteLoHiW,
   input  logic [63:0] loHi_dataW,
   input  logic [31:0] InstructW,
   input  logic [4:0]  A1D,
   input  logic [4:0]  A2D,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [31:0] HiD,
   output logic [31:0] LoD,
   output logic [31:0] ResultW,
   output logic        HaltW,
   output logic [31:0] RetireCount
);

   logic [31:0] r_gpr [0:31];
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_halted;
   logic [31:0] r_retire;

   logic        w_commit;
   logic        w_gpr_we;
   logic        w_lohi_we;
   logic        w_break;
   logic        w_retire;
   logic [31:0] w_result;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;

   // Once halted, the stage freezes all architectural state until reset.
   assign w_commit  = ~r_halted;
   assign w_gpr_we  = RegWriteW & (WriteRegW != 5'd0) & w_commit;
   assign w_lohi_we = WriteLoHiW & w_commit;
   assign w_break   = (InstructW[31:26] == 6'h00) && (InstructW[5:0] == 6'h0D) && w_commit;
   assign w_retire  = (InstructW != 32'd0) && w_commit;

   // Write-back mux: link address wins over load data, load data over ALU result.
   always_comb begin
      w_result = ALUOutW;
      if (LinkW)
         w_result = PCPlus8W;
      else if (MemtoRegW)
         w_result = ReadDataW;
   end

   // Decode read ports with same-cycle write-through so W->D needs no stall.
   always_comb begin
      w_rd1 = 32'd0;
      w_rd2 = 32'd0;
      if (A1D != 5'd0) begin
         if (w_gpr_we && (WriteRegW == A1D))
            w_rd1 = w_result;
         else
            w_rd1 = r_gpr[A1D];
      end
      if (A2D != 5'd0) begin
         if (w_gpr_we && (WriteRegW == A2D))
            w_rd2 = w_result;
         else
            w_rd2 = r_gpr[A2D];
      end
   end

   // GPR commit; entry 0 is never written and reads are masked to zero anyway.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 32; i++)
            r_gpr[i] <= 32'd0;
      end else if (w_gpr_we) begin
         r_gpr[WriteRegW] <= w_result;
      end
   end

   // HI/LO commit, independent of the GPR write in the same cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_lohi_we) begin
         r_hi <= loHi_dataW[63:32];
         r_lo <= loHi_dataW[31:0];
      end
   end

   // Sticky halt on BREAK; only reset clears it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_halted <= 1'b0;
      else if (w_break)
         r_halted <= 1'b1;
   end

   // Retired-instruction counter; bubbles are all-zero words, BREAK itself counts.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_retire <= 32'd0;
      else if (w_retire)
         r_retire <= r_retire + 32'd1;
   end

   assign ResultW     = w_result;
   assign RD1D        = w_rd1;
   assign RD2D        = w_rd2;
   assign HiD         = w_lohi_we ? loHi_dataW[63:32] : r_hi;
   assign LoD         = w_lohi_we ? loHi_dataW[31:0]  : r_lo;
   assign HaltW       = r_halted;
   assign RetireCount = r_retire;

endmodule
